// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data memory controller:
// access size encodings, FSM state type and alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A half must sit on an even byte, a word on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] o;
    case (size)
      SZ_BYTE: o = off;
      SZ_HALF: o = {off[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte-enable mask, store data replication
// across lanes and load extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rext
);

  logic [31:0] rshift;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // Little-endian lanes: shifting by 8*off brings the selected byte to the bottom.
  assign rshift = rword >> {off, 3'b000};
  assign bsel   = rshift[7:0];
  assign hsel   = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be     = 4'b1111;
    wlanes = wdata;
    rext   = rword;
    case (size)
      SZ_BYTE: begin
        be     = 4'b0001 << off;
        wlanes = {4{wdata[7:0]}};
        rext   = {{24{sext & bsel[7]}}, bsel};
      end
      SZ_HALF: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
        rext   = {{16{sext & hsel[15]}}, hsel};
      end
      default: begin
        be     = 4'b1111;
        wlanes = wdata;
        rext   = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory with a programmable number of wait states and pipeline stall.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output state_t      fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Handshake: a request is taken when req=1 in IDLE; the pipeline must hold
  // req (and sees stall=1) until the one-cycle done pulse in RESP.
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       access;
  logic       accept;

  logic                  cap_we;
  logic [1:0]            cap_size;
  logic                  cap_sext;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [1:0]            cap_off;
  logic [31:0]           cap_wdata;
  logic                  cap_mis;

  logic [1:0]  req_off;
  logic        req_mis;
  logic        unused_addr_hi;

  logic [31:0] mem [DEPTH];
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] rext;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_off = addr[1:0];
  assign req_mis = is_misaligned(size, addr[1:0]);
`else
  assign req_off = align_off(size, addr[1:0]);
  assign req_mis = 1'b0;
`endif

  // Upper address bits wrap within the array.
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  assign accept = (state == ST_IDLE) && req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= we;
      cap_size  <= size;
      cap_sext  <= sext;
      cap_idx   <= addr[DEPTH_LOG2+1:2];
      cap_off   <= req_off;
      cap_wdata <= wdata;
      cap_mis   <= req_mis;
    end
  end

  assign rword = mem[cap_idx];

  dmem_lane_align u_align (
    .size   (cap_size),
    .sext   (cap_sext),
    .off    (cap_off),
    .wdata  (cap_wdata),
    .rword  (rword),
    .be     (be),
    .wlanes (wlanes),
    .rext   (rext)
  );

  // Array is never cleared; reset only blocks a store still in flight.
  always_ff @(posedge clk) begin
    if (!rst && access && cap_we && !cap_mis) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[cap_idx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (access && !cap_we && !cap_mis) begin
      rdata <= rext;
    end
  end

  assign done      = (state == ST_RESP);
  assign err       = (state == ST_RESP) && cap_mis;
  assign stall     = req && (state != ST_RESP);
  assign fsm_state = state;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: directed vectors, reset abort, wrap-around,
// randomized accesses against a byte-level reference model, zero-wait streaming.
module tb_dmem_wait_ctrl;
  import dmem_pkg::*;

  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, err;
  state_t      fsm_state;

  logic        req0, we0, sext0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        stall0, done0, err0;
  state_t      fsm_state0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rd = 32'd0;

  always #5 clk = ~clk;

  dmem_wait_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .err(err), .fsm_state(fsm_state)
  );

  dmem_wait_ctrl #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .sext(sext0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .stall(stall0), .done(done0),
    .err(err0), .fsm_state(fsm_state0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: walks bytes individually rather than via lane masks.
  task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] exp_rd, output logic exp_err);
    int nb, off, idx;
    logic [31:0] v;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    idx = int'(a[11:2]);
    exp_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((off % nb) != 0) exp_err = 1'b1;
`else
    off = off - (off % nb);
`endif
    if (!exp_err) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[idx][8*(off+i) +: 8] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
        if (sx && nb < 4 && v[8*nb-1]) begin
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        ref_rd = v;
      end
    end
    exp_rd = ref_rd;
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] er;
    logic        ee;
    int          lat;
    bit          got;
    model(w, sz, sx, a, d, er, ee);
    exp_q.push_back(er);
    @(posedge clk); #1;
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (done) begin
        got = 1;
      end else begin
        chk("stall_pending", {31'd0, stall}, 32'd1);
        lat++;
        @(posedge clk); #1;
        // Scramble request fields: only captured values may matter now.
        we = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
        sext = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      end
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      chk("latency", 32'(lat), 32'(WAITC + 2));
      chk("stall_in_resp", {31'd0, stall}, 32'd0);
      chk("err", {31'd0, err}, {31'd0, ee});
      chk("rdata", rdata, exp_q.pop_front());
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    logic [31:0] ra;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; sext = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b1; size0 = 2'b10; sext0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    chk("rst_rdata0", rdata0, 32'd0);

    access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("word_load", rdata, 32'hDEADBEEF);

    access(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h80);
    chk("store_keeps_rdata", rdata, 32'hDEADBEEF);
    access(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    chk("byte_sext", rdata, 32'hFFFFFF80);
    access(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
    chk("byte_zext", rdata, 32'h00000080);
    access(1'b0, SZ_WORD_ALT, 1'b0, 32'h10, 32'h0);
    chk("byte_merge", rdata, 32'h80ADBEEF);

    access(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hAAAAAAAA);
    access(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h1234);
    access(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    chk("half_merge", rdata, 32'h1234AAAA);
    access(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0);
    chk("half_sext", rdata, 32'hFFFFAAAA);

    access(1'b0, SZ_WORD, 1'b0, 32'h1010, 32'h0);
    chk("addr_wrap", rdata, 32'h80ADBEEF);

    access(1'b1, SZ_WORD, 1'b0, 32'h11, 32'h55667788);
    access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_store", rdata, 32'h80ADBEEF);
`else
    chk("misalign_store", rdata, 32'h55667788);
`endif

    // Store aborted by reset while waiting.
    access(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11111111);
    access(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    saw = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h40; wdata = 32'h22222222;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) saw = 1;
      @(posedge clk); #1;
      req = 1'b0;
      rst = (c == 1);
    end
    ref_rd = 32'd0;
    chk("abort_no_done", {31'd0, saw}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    access(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    chk("abort_mem", rdata, 32'h11111111);

    // Randomized region 0x100..0x13F, initialised by word stores first.
    for (int i = 0; i < 16; i++) access(1'b1, SZ_WORD, 1'b0, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 30; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 63));
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ra, $urandom);
    end

    // Zero wait states, request held high: done every third cycle.
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h0BADF00D;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("w0_done", {31'd0, done0}, (c % 3 == 2) ? 32'd1 : 32'd0);
      chk("w0_stall", {31'd0, stall0}, (c % 3 == 2) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
